// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and lamp codes for the N-phase intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } state_e;

  // Per-phase lamp encoding {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the timebase/demand side and the sequencer core.
// master: the controlling environment; slave: the sequencer.
interface traffic_phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
);
  localparam int PH_W = $clog2(NUM_PHASES);

  logic                        tick;
  logic [NUM_PHASES-1:0]       req;
  logic [NUM_PHASES*CNT_W-1:0] green_time;
  logic [CNT_W-1:0]            yellow_time;
  logic [CNT_W-1:0]            allred_time;
  logic                        emerg;
  logic [PH_W-1:0]             emerg_phase;
  logic [NUM_PHASES*3-1:0]     light;
  logic [PH_W-1:0]             cur_phase;
  logic [1:0]                  state;
  logic                        emerg_active;

  modport master (
    output tick, req, green_time, yellow_time, allred_time, emerg, emerg_phase,
    input  light, cur_phase, state, emerg_active
  );

  modport slave (
    input  tick, req, green_time, yellow_time, allred_time, emerg, emerg_phase,
    output light, cur_phase, state, emerg_active
  );

endinterface

// File: rtl/traffic_phase_sequencer_rr_select.sv
// Rotating-priority phase search: first requesting phase after i_cur_phase,
// wrapping, with i_cur_phase itself considered last. No demand -> next phase.
module traffic_rr_select #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] i_req,
  input  logic [PH_W-1:0]       i_cur_phase,
  output logic [PH_W-1:0]       o_next_phase
);

  logic            w_found;
  logic [PH_W-1:0] w_idx;

  // Scan offsets 1..NUM_PHASES; the first hit wins
  always_comb begin
    w_found      = 1'b0;
    w_idx        = '0;
    o_next_phase = PH_W'((32'(i_cur_phase) + 32'd1) % NUM_PHASES);
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      w_idx = PH_W'((32'(i_cur_phase) + k) % NUM_PHASES);
      if (!w_found && i_req[w_idx]) begin
        o_next_phase = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase intersection controller: ALL_RED -> GREEN -> YELLOW -> ALL_RED,
// tick-driven per-state timer, demand-based phase skipping.
// Optional emergency pre-emption enabled by defining EMERGENCY_PREEMPT_EN.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst,
  traffic_phase_sequencer_if.slave bus
);
  import traffic_pkg::*;

  localparam int PH_W = $clog2(NUM_PHASES);

  state_e                  r_state, w_state_nxt;
  logic [PH_W-1:0]         r_phase, w_phase_nxt;
  logic [PH_W-1:0]         w_rr_next, w_sel;
  logic [CNT_W-1:0]        r_timer, w_timer_nxt;
  logic [NUM_PHASES*3-1:0] r_light, w_light_nxt;
  logic                    r_emerg_act, w_emerg_act_nxt;
  logic                    w_emerg_now;
  logic [PH_W-1:0]         w_emerg_ph;

  // A programmed duration of zero still occupies one tick
  function automatic logic [CNT_W-1:0] load_dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  traffic_rr_select #(
    .NUM_PHASES(NUM_PHASES),
    .PH_W      (PH_W)
  ) u_rr_select (
    .i_req       (bus.req),
    .i_cur_phase (r_phase),
    .o_next_phase(w_rr_next)
  );

`ifdef EMERGENCY_PREEMPT_EN
  logic [PH_W-1:0] r_emerg_ph;

  assign w_emerg_now = bus.emerg && ({1'b0, bus.emerg_phase} < (PH_W+1)'(NUM_PHASES));
  assign w_emerg_ph  = w_emerg_now ? bus.emerg_phase : r_emerg_ph;

  // Remember the requested phase so a request released during YELLOW/ALL_RED
  // is still served
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_emerg_ph <= '0;
    end else if (w_emerg_now) begin
      r_emerg_ph <= bus.emerg_phase;
    end
  end
`else
  logic w_unused_emerg;

  assign w_emerg_now    = 1'b0;
  assign w_emerg_ph     = '0;
  assign w_unused_emerg = bus.emerg ^ (^bus.emerg_phase);
`endif

  // Next-state, next-phase and timer reload/countdown
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_timer_nxt     = r_timer;
    w_emerg_act_nxt = r_emerg_act | w_emerg_now;
    w_sel           = (w_emerg_now || r_emerg_act) ? w_emerg_ph : w_rr_next;
    case (r_state)
      ST_ALL_RED: begin
        if (bus.tick) begin
          if (r_timer == CNT_W'(1)) begin
            w_state_nxt = ST_GREEN;
            w_phase_nxt = w_sel;
            w_timer_nxt = load_dur(bus.green_time[w_sel*CNT_W +: CNT_W]);
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
      end
      ST_GREEN: begin
        if (w_emerg_now && (r_phase != w_emerg_ph)) begin
          w_state_nxt = ST_YELLOW;
          w_timer_nxt = load_dur(bus.yellow_time);
        end else if (w_emerg_now) begin
          w_timer_nxt = r_timer;
        end else if (bus.tick) begin
          if (r_timer == CNT_W'(1)) begin
            w_state_nxt = ST_YELLOW;
            w_timer_nxt = load_dur(bus.yellow_time);
            if (r_emerg_act && (r_phase == w_emerg_ph)) begin
              w_emerg_act_nxt = 1'b0;
            end
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
      end
      ST_YELLOW: begin
        if (bus.tick) begin
          if (r_timer == CNT_W'(1)) begin
            w_state_nxt = ST_ALL_RED;
            w_timer_nxt = load_dur(bus.allred_time);
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_ALL_RED;
        w_timer_nxt = load_dur(bus.allred_time);
      end
    endcase
  end

  // Lamp pattern decoded from the next state so lamps change with the state
  always_comb begin
    w_light_nxt = {NUM_PHASES{LAMP_RED}};
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      if (w_phase_nxt == PH_W'(p)) begin
        if (w_state_nxt == ST_GREEN) begin
          w_light_nxt[p*3 +: 3] = LAMP_GRN;
        end else if (w_state_nxt == ST_YELLOW) begin
          w_light_nxt[p*3 +: 3] = LAMP_YEL;
        end
      end
    end
  end

  // State, phase, timer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_ALL_RED;
      r_phase     <= PH_W'(NUM_PHASES - 1);
      r_timer     <= load_dur(bus.allred_time);
      r_light     <= {NUM_PHASES{LAMP_RED}};
      r_emerg_act <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_timer     <= w_timer_nxt;
      r_light     <= w_light_nxt;
      r_emerg_act <= w_emerg_act_nxt;
    end
  end

  assign bus.light        = r_light;
  assign bus.cur_phase    = r_phase;
  assign bus.state        = r_state;
  assign bus.emerg_active = r_emerg_act;

endmodule
